// File: rtl/button_pkg.sv
// Shared constants and helpers for the multi-channel button debouncer.
// State codes name the implicit per-channel debounce phases.
package button_pkg;

  localparam int DEF_DEBOUNCE_CLK_CNT = 65536;
  localparam int DEF_SYNC_STAGES      = 2;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_QUAL_PRESS = 2'd1;
  localparam logic [1:0] ST_PRESSED    = 2'd2;
  localparam logic [1:0] ST_QUAL_REL   = 2'd3;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: synchroniser, symmetric filter,
// press/release pulses and optional long-press pulse.
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CLK_CNT   = DEF_DEBOUNCE_CLK_CNT,
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter bit ACTIVE_LOW_IN      = 1'b0,
  parameter int LONG_PRESS_CLK_CNT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_state,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int CW = cnt_width(DEBOUNCE_CLK_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CLK_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;
  logic                   diff;
  logic                   done;
  logic [1:0]             dbg_state;

  assign s    = sync[SYNC_STAGES-1] ^ ACTIVE_LOW_IN;
  assign diff = s ^ btn_state;
  assign done = diff && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= {SYNC_STAGES{ACTIVE_LOW_IN}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn_in};
    end
  end

  // any cycle of agreement restarts qualification
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_state   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      cnt         <= '0;
    end else begin
      btn_press   <= done && s;
      btn_release <= done && !s;
      if (!diff) begin
        cnt <= '0;
      end else if (done) begin
        btn_state <= s;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  generate
    if (LONG_PRESS_CLK_CNT > 0) begin : g_long
      localparam int HW = cnt_width(LONG_PRESS_CLK_CNT + 1);
      localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CLK_CNT);
      localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_PRESS_CLK_CNT - 1);
      localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

      logic [HW-1:0] hold;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          hold     <= '0;
          btn_long <= 1'b0;
        end else begin
          btn_long <= btn_state && (hold == HOLD_FIRE);
          if (!btn_state) begin
            hold <= '0;
          end else if (hold != HOLD_MAX) begin
            hold <= hold + HOLD_ONE;
          end
        end
      end
    end else begin : g_no_long
      assign btn_long = 1'b0;
    end
  endgenerate

  always_comb begin
    dbg_state = ST_IDLE;
    unique case (1'b1)
      !btn_state && !diff: dbg_state = ST_IDLE;
      !btn_state &&  diff: dbg_state = ST_QUAL_PRESS;
       btn_state && !diff: dbg_state = ST_PRESSED;
      default:             dbg_state = ST_QUAL_REL;
    endcase
  end

  a_press_src: assert property (
    @(posedge clk) disable iff (!reset)
    btn_press |-> $past(dbg_state) == ST_QUAL_PRESS);

  a_rel_src: assert property (
    @(posedge clk) disable iff (!reset)
    btn_release |-> $past(dbg_state) == ST_QUAL_REL);

endmodule

// File: rtl/button_debouncer_multi.sv
// NUM_CH independent button debouncers in one clock domain.
// Wiring only; each channel is self-contained.
module button_debouncer_multi
  import button_pkg::*;
#(
  parameter int NUM_CH             = 4,
  parameter int DEBOUNCE_CLK_CNT   = DEF_DEBOUNCE_CLK_CNT,
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter bit ACTIVE_LOW_IN      = 1'b0,
  parameter int LONG_PRESS_CLK_CNT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] btn_state,
  output logic [NUM_CH-1:0] btn_press,
  output logic [NUM_CH-1:0] btn_release,
  output logic [NUM_CH-1:0] btn_long
);

  generate
    if (NUM_CH < 1 || DEBOUNCE_CLK_CNT < 2 || SYNC_STAGES < 2)
    begin : g_bad_params
      $fatal(1, "button_debouncer_multi: illegal parameters");
    end
  endgenerate

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CLK_CNT   (DEBOUNCE_CLK_CNT),
      .SYNC_STAGES        (SYNC_STAGES),
      .ACTIVE_LOW_IN      (ACTIVE_LOW_IN),
      .LONG_PRESS_CLK_CNT (LONG_PRESS_CLK_CNT)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .btn_in      (btn_in[i]),
      .btn_state   (btn_state[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_long    (btn_long[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer_multi.sv
// Scoreboard bench: active-high and active-low builds side by side
// against a timestamp-based reference model.
module tb_button_debouncer_multi;

  localparam int DEB  = 8;
  localparam int SYNC = 2;
  localparam int LONG = 32;

  logic       clk;
  logic       reset;
  logic [1:0] in_a, in_b;
  logic [1:0] st_a, press_a, rel_a, long_a;
  logic [1:0] st_b, press_b, rel_b, long_b;
  logic [15:0] obs;

  int vectors;
  int miscompares;

  logic [15:0] exp_q[$];

  button_debouncer_multi #(
    .NUM_CH(2), .DEBOUNCE_CLK_CNT(DEB), .SYNC_STAGES(SYNC),
    .ACTIVE_LOW_IN(1'b0), .LONG_PRESS_CLK_CNT(LONG)
  ) dut_a (
    .clk(clk), .reset(reset), .btn_in(in_a),
    .btn_state(st_a), .btn_press(press_a),
    .btn_release(rel_a), .btn_long(long_a)
  );

  button_debouncer_multi #(
    .NUM_CH(2), .DEBOUNCE_CLK_CNT(DEB), .SYNC_STAGES(SYNC),
    .ACTIVE_LOW_IN(1'b1), .LONG_PRESS_CLK_CNT(LONG)
  ) dut_b (
    .clk(clk), .reset(reset), .btn_in(in_b),
    .btn_state(st_b), .btn_press(press_b),
    .btn_release(rel_b), .btn_long(long_b)
  );

  // bit k: channel k of {B1,B0,A1,A0}
  assign obs = {long_b, long_a, rel_b, rel_a,
                press_b, press_a, st_b, st_a};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a level flips once it has disagreed with the
  // stable level on DEB consecutive edges since the last agreement.
  int cyc;
  int last_agree[4];
  int press_t[4];
  bit st_m[4];
  bit line[4][SYNC];

  always @(posedge clk or negedge reset) begin
    int n;
    bit s;
    logic [15:0] v;
    logic [3:0] inp;
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        st_m[k] = 1'b0;
        last_agree[k] = cyc;
        press_t[k] = 0;
        for (int j = 0; j < SYNC; j++) line[k][j] = (k >= 2);
      end
      exp_q.delete();
      exp_q.push_back(16'h0);
    end else begin
      cyc = cyc + 1;
      n = cyc;
      v = '0;
      inp = {in_b, in_a};
      for (int k = 0; k < 4; k++) begin
        s = line[k][SYNC-1] ^ (k >= 2);
        if (st_m[k] && (n - press_t[k] == LONG)) v[12+k] = 1'b1;
        if (s == st_m[k]) begin
          last_agree[k] = n;
        end else if (n - last_agree[k] == DEB) begin
          st_m[k] = s;
          last_agree[k] = n;
          if (s) begin
            v[4+k] = 1'b1;
            press_t[k] = n;
          end else begin
            v[8+k] = 1'b1;
          end
        end
        v[k] = st_m[k];
        for (int j = SYNC - 1; j > 0; j--) line[k][j] = line[k][j-1];
        line[k][0] = inp[k];
      end
      exp_q.push_back(v);
    end
  end

  always @(negedge clk) begin
    logic [15:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL scoreboard t=%0t got %h want %h", $time, obs, e);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic measure(input int idx, input int limit, output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!obs[idx] && edges <= limit);
  endtask

  int e;
  int extra;
  int bad;
  int ncyc;
  int len;
  int rem[4];
  bit lvl;

  initial begin
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    reset = 1'b0;
    in_a = 2'b00;
    in_b = 2'b11;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_no_event", int'(obs), 0);

    // clean press on A0
    @(negedge clk) in_a[0] = 1'b1;
    measure(4, 40, e);
    chk("press_lat_a0", e, 10);
    chk("state_a0_up", int'(obs[0]), 1);

    // long press on A1
    @(negedge clk) in_a[1] = 1'b1;
    measure(5, 40, e);
    chk("press_lat_a1", e, 10);
    measure(13, 60, e);
    chk("long_lat_a1", e, LONG);
    extra = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (obs[13]) extra++;
    end
    chk("long_once_a1", extra, 0);
    @(negedge clk) in_a[1] = 1'b0;
    repeat (20) @(negedge clk);

    // asynchronous reset while A0 is pressed
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("rst_clear", int'(obs), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    measure(4, 40, e);
    chk("press_after_rst", e, 10);

    // release with a glitch back high
    @(negedge clk) in_a[0] = 1'b0;
    repeat (3) @(negedge clk);
    in_a[0] = 1'b1;
    repeat (5) @(negedge clk);
    in_a[0] = 1'b0;
    measure(8, 40, e);
    chk("release_lat_a0", e, 10);
    extra = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (obs[8]) extra++;
    end
    chk("release_once_a0", extra, 0);

    // bounce with phases shorter than the filter
    bad = 0;
    ncyc = 0;
    lvl = 1'b0;
    while (ncyc < 200) begin
      lvl = ~lvl;
      len = $urandom_range(1, DEB - 1);
      repeat (len) begin
        @(negedge clk) in_a[0] = lvl;
        if (obs[0] || obs[4] || obs[8]) bad++;
        ncyc++;
      end
    end
    @(negedge clk) in_a[0] = 1'b0;
    chk("bounce_quiet", bad, 0);
    @(negedge clk) in_a[0] = 1'b1;
    measure(4, 40, e);
    chk("press_after_bounce", e, 10);
    @(negedge clk) in_a[0] = 1'b0;
    repeat (20) @(negedge clk);

    // active-low build
    @(negedge clk) in_b[0] = 1'b0;
    measure(6, 40, e);
    chk("press_lat_b0", e, 10);
    @(negedge clk) in_b[0] = 1'b1;
    repeat (20) @(negedge clk);

    // random run on all channels
    for (int k = 0; k < 4; k++) rem[k] = $urandom_range(1, 60);
    repeat (4000) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (rem[k] == 0) begin
          if (k < 2) in_a[k] = ~in_a[k];
          else in_b[k-2] = ~in_b[k-2];
          rem[k] = $urandom_range(1, 60);
        end else begin
          rem[k]--;
        end
      end
    end
    in_a = 2'b00;
    in_b = 2'b11;
    repeat (50) @(negedge clk);
    chk("final_idle", int'(obs[3:0]), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_debouncer_multi.md
Name: button_debouncer_multi

Overview:
- Parametrised successor to the single-channel debouncer; debounces NUM_CH raw push-button or switch inputs in parallel in a single clock domain.
- Each channel has:
  - an input synchroniser;
  - optional input inversion;
  - symmetric filtering, so press and release are both debounced;
  - one-cycle press/release event pulses;
  - an optional long-press event.
- Sits between board pins and user logic (menu FSMs, counters).

Parameters:
- NUM_CH, 4: number of independent channels (>=1).
- DEBOUNCE_CLK_CNT, 65536: consecutive cycles a synchronised input must differ from the stable state before the state flips (>=2).
- SYNC_STAGES, 2: synchroniser flop depth per channel (>=2).
- ACTIVE_LOW_IN, 0: 1 = inputs idle high and are inverted after synchronisation.
- LONG_PRESS_CLK_CNT, 0: cycles of stable-pressed state before btn_long fires; 0 disables the feature.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- btn_in  in  NUM_CH  raw asynchronous button inputs
- btn_state  out  NUM_CH  debounced level, 1 = pressed
- btn_press  out  NUM_CH  one-cycle pulse on the 0->1 transition of btn_state
- btn_release  out  NUM_CH  one-cycle pulse on the 1->0 transition of btn_state
- btn_long  out  NUM_CH  one-cycle pulse, once per press, after a long hold

Behaviour:
- Reset, while reset=0, asynchronous:
  - all outputs, counters and state go to 0;
  - synchroniser flops load the idle level: 1 if ACTIVE_LOW_IN else 0.
  - Result: deasserting reset with buttons idle produces no events.
- Synchroniser: s = last stage of a SYNC_STAGES flop chain on btn_in[i], XOR ACTIVE_LOW_IN. No other logic reads btn_in.
- Debounce counter:
  - width $clog2(DEBOUNCE_CLK_CNT), per channel, separate from the long-press counter;
  - if s == btn_state: cnt <= 0;
  - else if cnt == DEBOUNCE_CLK_CNT-1: btn_state <= s, cnt <= 0;
  - else cnt <= cnt+1.
  - btn_state therefore flips on the DEBOUNCE_CLK_CNT-th consecutive edge with s != btn_state.
  - Any single cycle of agreement restarts the count. Counter never wraps.
- Latency: a clean step on btn_in reaches btn_state SYNC_STAGES + DEBOUNCE_CLK_CNT edges later.
- Events: btn_press/btn_release are registered and high for exactly the first cycle in which btn_state shows its new value. They are never both high on one channel.
- Long press (LONG_PRESS_CLK_CNT > 0):
  - hold counter, width $clog2(LONG_PRESS_CLK_CNT+1), clears while btn_state=0 and counts while btn_state=1;
  - when the counter reaches LONG_PRESS_CLK_CNT-1, btn_long pulses on the next cycle, then the counter saturates;
  - one btn_long per press; re-arms only after btn_state returns to 0.
  - If LONG_PRESS_CLK_CNT == 0, btn_long is tied to 0 and no hold counter is generated.
- Channels are fully independent: simultaneous presses on several channels give simultaneous pulses.
- Reset mid-operation: btn_state drops asynchronously with no btn_release pulse. After reset, a still-held button must re-qualify for the full latency and then produce btn_press.
- Per-channel state machine (implicit in btn_state + counters):
  - IDLE -> QUAL_PRESS when s=1;
  - QUAL_PRESS -> PRESSED on count done, or back to IDLE on s=0;
  - PRESSED -> QUAL_REL when s=0;
  - QUAL_REL -> IDLE on count done, or back to PRESSED on s=1.
- Illegal parameters (DEBOUNCE_CLK_CNT<2, SYNC_STAGES<2, NUM_CH<1) are caught by an elaboration-time check that stops elaboration.

Decomposition:
- Shared package button_pkg:
  - width helper function cnt_width(n) = max(1, $clog2(n));
  - default constants for DEBOUNCE_CLK_CNT and SYNC_STAGES;
  - per-channel state encoding localparams (IDLE, QUAL_PRESS, PRESSED, QUAL_REL) for assertion/debug use.
- Sub-module debounce_channel: one instance per channel, generate loop over NUM_CH. It contains the synchroniser, debounce counter, event pulses and hold counter. The top level is wiring only.

Test Plan:
All tests use NUM_CH=2, DEBOUNCE_CLK_CNT=8, SYNC_STAGES=2, LONG_PRESS_CLK_CNT=32, ACTIVE_LOW_IN=0.
- Clean press: btn_in[0] 0->1 and held.
  - btn_state[0] rises exactly 10 edges later.
  - btn_press[0] is high for 1 cycle in that same cycle.
  - Channel 1 stays silent.
- Bounce rejection: btn_in[0] toggles with 1..7-cycle high/low phases for 200 cycles. Expect btn_state and all pulses at 0 throughout; then a steady high gives a single press 10 edges later.
- Release: from pressed, btn_in[0] -> 0 with a 5-cycle glitch back to 1 after 3 cycles. btn_state falls 10 edges after the glitch ends, with exactly one btn_release pulse.
- Long press: hold btn_in[1]=1 for 100 cycles. Expect btn_long[1] pulses exactly once, 32 cycles after btn_press[1]; no further pulses until release and a new press.
- Reset mid-press: pull reset=0 while btn_state[0]=1.
  - Outputs go 0 immediately, with no release pulse.
  - After reset=1 with the input still high, expect btn_press[0] after 10 edges.
- Active-low build (ACTIVE_LOW_IN=1): inputs idle at 1 through reset release give no events; driving btn_in[0]=0 produces btn_press[0] after 10 edges.
